// File: rtl/pc_jump_sequencer.sv
// pc_jump_sequencer: fetch/branch sequencer for the 8-bit CPU.
// Owns the program counter. Walks the opcode and operand fetches, then resolves
// JMP/JZ/JNZ/JC/CALL/RET/HALT. The jump mux is driven through jmp_en/jmp_op.
// Opcodes outside the jump family go to the execute unit as a one-cycle exec_strobe.
//
// Optional feature macro: PC_CALL_STACK_EN
//   Defined:   CALL pushes the return address and RET pops it. Overflow and underflow
//              set stack_err (sticky) and send the sequencer to HALT.
//   Undefined: there is no return stack. CALL acts as JMP, RET as a 1-byte NOP, and
//              stack_err is tied to 0.
//
// Parameters:
//   RESET_VECTOR  PC value loaded on reset
//   STACK_DEPTH   return-stack entries (power of 2, 2..8); used only with the macro
// The 7 ns NAND propagation delay on jmp_en/jmp_op is a timing-analysis figure and
// is not modelled in this RTL.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               freeze: state/pc held, mem_rd=0, no strobes or jumps
//   instr, instr_valid  program-memory byte and its valid, sampled while mem_rd=1
//   flag_z, flag_c      ALU flags, sampled in DECIDE
//   mem_rd, pc          fetch request at address pc
//   jmp_en, jmp_op      jump mux select and target (target is 0 when not jumping)
//   exec_strobe,exec_op one-cycle pulse with the latched non-jump opcode
//   halted, stack_err   HALT state indicator, sticky return-stack error

module pc_jump_sequencer #(
    parameter logic [7:0]  RESET_VECTOR = 8'h00,
    parameter int unsigned STACK_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       mem_rd,
    output logic [7:0] pc,
    output logic       jmp_en,
    output logic [7:0] jmp_op,
    output logic       exec_strobe,
    output logic [7:0] exec_op,
    output logic       halted,
    output logic       stack_err
);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("STACK_DEPTH must be a power of 2 in 2..8");
    end

    localparam logic [3:0] OpJmp  = 4'h0;
    localparam logic [3:0] OpJz   = 4'h1;
    localparam logic [3:0] OpJnz  = 4'h2;
    localparam logic [3:0] OpJc   = 4'h3;
    localparam logic [3:0] OpCall = 4'h4;
    localparam logic [3:0] OpRet  = 4'h5;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        StFetch,
        StOperand,
        StDecide,
        StJump,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] pc_inc;
    logic [3:0] opcode_q, opcode_d;   // only the low nibble matters once in the jump family
    logic [7:0] target_q, target_d;
    logic [7:0] exec_op_q, exec_op_d;
    logic       strobe_q, strobe_d;

    assign pc_inc = pc_q + 8'd1;

`ifdef PC_CALL_STACK_EN
    localparam int unsigned SpW = $clog2(STACK_DEPTH) + 1;

    logic [SpW-1:0] sp_q, sp_d;
    logic [SpW-1:0] sp_m1;
    logic [7:0]     stack_q [STACK_DEPTH];
    logic           push, pop;
    logic           full, empty;
    logic           err_q, err_d;

    assign sp_m1 = sp_q - SpW'(1);
    assign full  = (sp_q == SpW'(STACK_DEPTH));
    assign empty = (sp_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        target_d  = target_q;
        exec_op_d = exec_op_q;
        // A pending strobe survives a stall so it is delivered once the stall lifts.
        strobe_d  = stall ? strobe_q : 1'b0;
`ifdef PC_CALL_STACK_EN
        err_d     = err_q;
        push      = 1'b0;
        pop       = 1'b0;
`endif
        if (!stall) begin
            unique case (state_q)
                StFetch: begin
                    if (instr_valid) begin
                        pc_d = pc_inc;
                        if (instr[7:4] != 4'hF) begin
                            exec_op_d = instr;
                            strobe_d  = 1'b1;
                        end else begin
                            opcode_d = instr[3:0];
                            case (instr[3:0])
                                OpJmp, OpJz, OpJnz, OpJc, OpCall: state_d = StOperand;
                                OpHalt:                           state_d = StHalt;
                                default:                          state_d = StDecide;
                            endcase
                        end
                    end
                end
                StOperand: begin
                    if (instr_valid) begin
                        target_d = instr;
                        pc_d     = pc_inc;
                        state_d  = StDecide;
                    end
                end
                StDecide: begin
                    state_d = StFetch;
                    case (opcode_q)
                        OpJmp: state_d = StJump;
                        OpJz:  if (flag_z)  state_d = StJump;
                        OpJnz: if (!flag_z) state_d = StJump;
                        OpJc:  if (flag_c)  state_d = StJump;
`ifdef PC_CALL_STACK_EN
                        OpCall: begin
                            if (full) begin
                                err_d   = 1'b1;
                                state_d = StHalt;
                            end else begin
                                push    = 1'b1;
                                state_d = StJump;
                            end
                        end
                        OpRet: begin
                            if (empty) begin
                                err_d   = 1'b1;
                                state_d = StHalt;
                            end else begin
                                pop      = 1'b1;
                                target_d = stack_q[sp_m1[SpW-2:0]];
                                state_d  = StJump;
                            end
                        end
`else
                        OpCall: state_d = StJump;
`endif
                        default: ;
                    endcase
                end
                StJump: begin
                    pc_d    = target_q;
                    state_d = StFetch;
                end
                StHalt: ;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_VECTOR;
            opcode_q  <= 4'h0;
            target_q  <= 8'h00;
            exec_op_q <= 8'h00;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            target_q  <= target_d;
            exec_op_q <= exec_op_d;
            strobe_q  <= strobe_d;
        end
    end

`ifdef PC_CALL_STACK_EN
    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q + SpW'(1);
        end else if (pop) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack contents need no reset; only the pointer defines validity.
    // In DECIDE, pc_q already points past the operand, so it is the return address.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[SpW-2:0]] <= pc_q;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    // mem_rd is gated by rst_n so that every output except pc is 0 while reset is held.
    assign mem_rd      = rst_n & ~stall & ((state_q == StFetch) | (state_q == StOperand));
    assign pc          = pc_q;
    assign jmp_en      = ~stall & (state_q == StJump);
    assign jmp_op      = jmp_en ? target_q : 8'h00;
    assign exec_strobe = strobe_q & ~stall;
    assign exec_op     = exec_op_q;
    assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Directed testbench for pc_jump_sequencer, with hand-computed expected values.
module tb_pc_jump_sequencer;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic [7:0] instr;
    logic       instr_valid;
    logic       flag_z;
    logic       flag_c;
    logic       mem_rd;
    logic [7:0] pc;
    logic       jmp_en;
    logic [7:0] jmp_op;
    logic       exec_strobe;
    logic [7:0] exec_op;
    logic       halted;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    pc_jump_sequencer #(
        .RESET_VECTOR(8'h00),
        .STACK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .mem_rd     (mem_rd),
        .pc         (pc),
        .jmp_en     (jmp_en),
        .jmp_op     (jmp_op),
        .exec_strobe(exec_strobe),
        .exec_op    (exec_op),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one memory byte with valid for a single cycle.
    task automatic feed(input logic [7:0] b);
        instr       = b;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 8'h00;
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        instr       = 8'h00;
        instr_valid = 1'b0;
        flag_z      = 1'b0;
        flag_c      = 1'b0;

        // Reset state
        #2;
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_mem_rd", mem_rd, 1'b0);
        check_eq("rst_jmp_en", jmp_en, 1'b0);
        check_eq("rst_jmp_op", jmp_op, 8'h00);
        check_eq("rst_strobe", exec_strobe, 1'b0);
        check_eq("rst_exec_op", exec_op, 8'h00);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_stack_err", stack_err, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("fetch_mem_rd", mem_rd, 1'b1);

        // 1: non-jump opcode
        feed(8'h12);
        check_eq("t1_strobe", exec_strobe, 1'b1);
        check_eq("t1_exec_op", exec_op, 8'h12);
        check_eq("t1_pc", pc, 8'h01);
        tick();
        check_eq("t1_strobe_off", exec_strobe, 1'b0);
        check_eq("t1_pc_wait", pc, 8'h01);

        // 2: JMP 40
        feed(8'hF0);
        check_eq("t2_pc_op", pc, 8'h02);
        check_eq("t2_mem_rd_op", mem_rd, 1'b1);
        feed(8'h40);
        check_eq("t2_pc_dec", pc, 8'h03);
        check_eq("t2_mem_rd_dec", mem_rd, 1'b0);
        tick();
        check_eq("t2_jmp_en", jmp_en, 1'b1);
        check_eq("t2_jmp_op", jmp_op, 8'h40);
        tick();
        check_eq("t2_pc", pc, 8'h40);
        check_eq("t2_jmp_en_off", jmp_en, 1'b0);
        check_eq("t2_jmp_op_off", jmp_op, 8'h00);
        check_eq("t2_mem_rd", mem_rd, 1'b1);

        // 3: conditional jumps
        do_reset();
        flag_z = 1'b0;
        feed(8'hF1);
        feed(8'h80);
        tick();
        check_eq("t3_jz_nt_pc", pc, 8'h02);
        check_eq("t3_jz_nt_jmp", jmp_en, 1'b0);
        check_eq("t3_jz_nt_rd", mem_rd, 1'b1);
        flag_z = 1'b1;
        feed(8'hF1);
        feed(8'h80);
        tick();
        check_eq("t3_jz_t_jmp", jmp_en, 1'b1);
        check_eq("t3_jz_t_op", jmp_op, 8'h80);
        tick();
        check_eq("t3_jz_t_pc", pc, 8'h80);
        feed(8'hF2);
        feed(8'h33);
        tick();
        check_eq("t3_jnz_nt_jmp", jmp_en, 1'b0);
        check_eq("t3_jnz_nt_pc", pc, 8'h82);
        flag_z = 1'b0;
        flag_c = 1'b1;
        feed(8'hF3);
        feed(8'h55);
        tick();
        check_eq("t3_jc_op", jmp_op, 8'h55);
        tick();
        check_eq("t3_jc_pc", pc, 8'h55);
        flag_c = 1'b0;

        // 4: pc wrap, then stall mid-OPERAND
        feed(8'hF0);
        feed(8'hFF);
        tick();
        tick();
        check_eq("t4_pc_ff", pc, 8'hFF);
        feed(8'h34);
        check_eq("t4_wrap_pc", pc, 8'h00);
        check_eq("t4_wrap_exec_op", exec_op, 8'h34);
        feed(8'hF0);
        check_eq("t4_op_pc", pc, 8'h01);
        stall       = 1'b1;
        instr       = 8'h77;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4_stall_pc", pc, 8'h01);
            check_eq("t4_stall_rd", mem_rd, 1'b0);
        end
        stall       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        #1;
        check_eq("t4_unstall_rd", mem_rd, 1'b1);
        check_eq("t4_unstall_pc", pc, 8'h01);
        feed(8'h60);
        check_eq("t4_after_op_pc", pc, 8'h02);
        tick();
        tick();
        check_eq("t4_jump_pc", pc, 8'h60);

        // Stall during the JUMP cycle holds the jump back
        feed(8'hF0);
        feed(8'h70);
        tick();
        stall = 1'b1;
        #1;
        check_eq("stall_jmp_en", jmp_en, 1'b0);
        check_eq("stall_jmp_op", jmp_op, 8'h00);
        tick();
        check_eq("stall_jmp_pc", pc, 8'h62);
        stall = 1'b0;
        #1;
        check_eq("unstall_jmp_op", jmp_op, 8'h70);
        tick();
        check_eq("unstall_jmp_pc", pc, 8'h70);

`ifndef PC_CALL_STACK_EN
        // Without the stack: CALL behaves as JMP, RET as a 1-byte NOP
        feed(8'hF4);
        feed(8'h25);
        tick();
        check_eq("call_jmp_en", jmp_en, 1'b1);
        check_eq("call_jmp_op", jmp_op, 8'h25);
        tick();
        check_eq("call_pc", pc, 8'h25);
        feed(8'hF5);
        check_eq("ret_nop_pc", pc, 8'h26);
        tick();
        check_eq("ret_nop_jmp", jmp_en, 1'b0);
        check_eq("ret_nop_pc2", pc, 8'h26);
        check_eq("ret_nop_rd", mem_rd, 1'b1);
        check_eq("ret_nop_err", stack_err, 1'b0);
        check_eq("ret_nop_halt", halted, 1'b0);
`else
        // 5: CALL/RET through the return stack
        do_reset();
        feed(8'hF0);
        feed(8'h10);
        tick();
        tick();
        check_eq("t5_pc10", pc, 8'h10);
        feed(8'hF4);
        feed(8'h20);
        check_eq("t5_call_pc", pc, 8'h12);
        tick();
        check_eq("t5_call_op", jmp_op, 8'h20);
        tick();
        check_eq("t5_call_tgt", pc, 8'h20);
        feed(8'hF5);
        tick();
        check_eq("t5_ret_en", jmp_en, 1'b1);
        check_eq("t5_ret_op", jmp_op, 8'h12);
        tick();
        check_eq("t5_ret_pc", pc, 8'h12);
        for (int i = 0; i < 4; i++) begin
            feed(8'hF4);
            feed(8'h30 + 8'(i * 16));
            tick();
            tick();
            check_eq("t5_nest_pc", pc, 8'h30 + 8'(i * 16));
            check_eq("t5_nest_err", stack_err, 1'b0);
        end
        feed(8'hF4);
        feed(8'h90);
        tick();
        check_eq("t5_ovf_err", stack_err, 1'b1);
        check_eq("t5_ovf_halt", halted, 1'b1);
        check_eq("t5_ovf_jmp", jmp_en, 1'b0);
        check_eq("t5_ovf_rd", mem_rd, 1'b0);
        do_reset();
        check_eq("t5_err_cleared", stack_err, 1'b0);
        feed(8'hF5);
        tick();
        check_eq("t5_unf_err", stack_err, 1'b1);
        check_eq("t5_unf_halt", halted, 1'b1);
`endif

        // 6: HALT is absorbing until reset
        do_reset();
        feed(8'hFF);
        check_eq("t6_halted", halted, 1'b1);
        check_eq("t6_mem_rd", mem_rd, 1'b0);
        instr       = 8'h12;
        instr_valid = 1'b1;
        tick();
        tick();
        instr_valid = 1'b0;
        check_eq("t6_still_halted", halted, 1'b1);
        check_eq("t6_no_strobe", exec_strobe, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_pc", pc, 8'h00);
        check_eq("t6_rst_halted", halted, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("t6_rd_after", mem_rd, 1'b1);

        // Reset during the JUMP cycle drops jmp_en without waiting for a clock
        feed(8'hF0);
        feed(8'h44);
        tick();
        check_eq("ajmp_en_pre", jmp_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ajmp_en_drop", jmp_en, 1'b0);
        check_eq("ajmp_op_drop", jmp_op, 8'h00);
        check_eq("ajmp_pc", pc, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
